// File: rtl/lsu_ctrl.sv
// Load/store controller between execute stage and single-port data memory.
// Optional misalignment detection is enabled by defining LSU_ERR_EN.
module lsu_ctrl #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [1:0]               req_size,
   input  logic                     req_unsigned,
   input  logic [ADDRESS_WIDTH+1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   output logic                     rsp_valid,
   output logic [DATA_WIDTH-1:0]    rsp_rdata,
   output logic                     rsp_err,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_a,
   output logic [DATA_WIDTH-1:0]    mem_wd,
   input  logic [DATA_WIDTH-1:0]    mem_rd,
   output logic [1:0]               state_dbg
);

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

   state_t                state;
   logic                  lat_we;
   logic [1:0]            lat_size;
   logic                  lat_uns;
   logic [1:0]            lat_lane;
   logic [DATA_WIDTH-1:0] lat_wdata;

   logic                  mis_flag;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_WIDTH-1:0] ld_data;
   logic [DATA_WIDTH-1:0] st_data;

`ifdef LSU_ERR_EN
   logic req_mis;
   always_comb begin
      req_mis = 1'b0;
      if (req_size == 2'b01)
         req_mis = req_addr[0];
      else if (req_size[1])
         req_mis = |req_addr[1:0];
   end
   assign mis_flag = req_mis;
`else
   // Without detection the lane logic below simply ignores the low address bits.
   assign mis_flag = 1'b0;
`endif

   assign req_ready = (state == IDLE) && rst_n;
   assign state_dbg = state;
   // Decoded from state so the strobe vanishes as soon as reset clears the state.
   assign mem_we    = (state == WRITE) || ((state == ACCESS) && lat_we && lat_size[1]);

   always_comb begin
      ld_byte = mem_rd[{lat_lane, 3'b000} +: 8];
      ld_half = lat_lane[1] ? mem_rd[31:16] : mem_rd[15:0];
      case (lat_size)
         2'b00:   ld_data = {{(DATA_WIDTH-8){~lat_uns & ld_byte[7]}}, ld_byte};
         2'b01:   ld_data = {{(DATA_WIDTH-16){~lat_uns & ld_half[15]}}, ld_half};
         default: ld_data = mem_rd;
      endcase
   end

   always_comb begin
      st_data = mem_rd;
      if (lat_size == 2'b00)
         st_data[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
      else
         st_data[{lat_lane[1], 4'b0000} +: 16] = lat_wdata[15:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lat_we    <= 1'b0;
         lat_size  <= 2'b00;
         lat_uns   <= 1'b0;
         lat_lane  <= 2'b00;
         lat_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         mem_a     <= '0;
         mem_wd    <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_we    <= req_we;
                  lat_size  <= req_size;
                  lat_uns   <= req_unsigned;
                  lat_lane  <= req_addr[1:0];
                  lat_wdata <= req_wdata;
                  if (mis_flag) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     state <= ACCESS;
                     mem_a <= req_addr[ADDRESS_WIDTH+1:2];
                     // Word store writes during ACCESS, so its data must be ready then.
                     if (req_we && req_size[1])
                        mem_wd <= req_wdata;
                  end
               end
            end
            ACCESS: begin
               if (!lat_we) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= ld_data;
               end else if (lat_size[1]) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= '0;
               end else begin
                  state  <= WRITE;
                  mem_wd <= st_data;
               end
            end
            WRITE: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
            end
            default: begin
               state     <= IDLE;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: driver pushes expected responses and writes,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [9:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_we;
   logic [7:0]  mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
   logic [1:0]  state_dbg;

   lsu_ctrl #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // Memory model with a side port so the bench can preload words.
   logic [31:0] mem [0:255];
   logic        tb_we = 1'b0;
   logic [7:0]  tb_wa = '0;
   logic [31:0] tb_wd = '0;
   assign mem_rd = mem[mem_a];
   always @(posedge clk) begin
      if (mem_we) mem[mem_a] <= mem_wd;
      else if (tb_we) mem[tb_wa] <= tb_wd;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] exp_rdata_q[$];
   logic [31:0] exp_err_q[$];
   logic [31:0] exp_lat_q[$];
   logic [31:0] exp_acc_q[$];
   logic [31:0] exp_wa_q[$];
   logic [31:0] exp_wd_q[$];

   int checks = 0;
   int failures = 0;
   int last_rsp_cyc = 0;
   logic sb_off = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic flag_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (rst_n && !sb_off) begin
         if (mem_we) begin
            if (exp_wa_q.size() == 0) flag_fail("unexpected_mem_we");
            else begin
               check("mem_a", {24'd0, mem_a}, exp_wa_q.pop_front());
               check("mem_wd", mem_wd, exp_wd_q.pop_front());
            end
         end
         if (rsp_valid) begin
            if (exp_rdata_q.size() == 0) flag_fail("unexpected_rsp_valid");
            else begin
               check("rsp_rdata", rsp_rdata, exp_rdata_q.pop_front());
               check("rsp_err", {31'd0, rsp_err}, exp_err_q.pop_front());
               check("rsp_latency", cyc - exp_acc_q.pop_front(), exp_lat_q.pop_front());
            end
            check("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
            last_rsp_cyc = cyc;
         end
      end
   end

   task automatic preload(input logic [7:0] idx, input logic [31:0] data);
      @(negedge clk);
      tb_we = 1'b1; tb_wa = idx; tb_wd = data;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                         input logic has_wr, input logic [7:0] wa, input logic [31:0] wd,
                         input logic hold, input logic b2b);
      logic acc;
      acc = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      for (int i = 0; i < 50 && !acc; i++) begin
         if (req_ready) begin
            acc = 1'b1;
            if (b2b) check("b2b_accept_cycle", cyc, last_rsp_cyc + 1);
            exp_rdata_q.push_back(exp_rdata);
            exp_err_q.push_back({31'd0, exp_err});
            exp_lat_q.push_back(exp_lat);
            exp_acc_q.push_back(cyc);
            if (has_wr) begin
               exp_wa_q.push_back({24'd0, wa});
               exp_wd_q.push_back(wd);
            end
         end else @(negedge clk);
      end
      if (!acc) flag_fail("accept_timeout");
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (exp_rdata_q.size() == 0 && exp_wa_q.size() == 0) break;
         @(negedge clk);
      end
      if (exp_rdata_q.size() != 0 || exp_wa_q.size() != 0) flag_fail("drain_timeout");
      @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_a", {24'd0, mem_a}, 32'd0);
      check("rst_mem_wd", mem_wd, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {31'd0, req_ready}, 32'd1);

      // Word store then word load
      do_req(1, 2'b10, 0, 10'h010, 32'hDEADBEEF, 32'h0, 0, 2, 1, 8'd4, 32'hDEADBEEF, 0, 0);
      do_req(0, 2'b10, 0, 10'h010, 32'h0, 32'hDEADBEEF, 0, 2, 0, 8'd0, 32'h0, 0, 0);
      do_req(0, 2'b11, 0, 10'h010, 32'h0, 32'hDEADBEEF, 0, 2, 0, 8'd0, 32'h0, 0, 0);
      drain();

      // Sub-word RMW stores
      preload(8'd2, 32'h11223344);
      preload(8'd3, 32'h01234567);
      do_req(1, 2'b00, 0, 10'h009, 32'h123456AA, 32'h0, 0, 3, 1, 8'd2, 32'h1122AA44, 0, 0);
      do_req(1, 2'b01, 0, 10'h00E, 32'h9999BEEF, 32'h0, 0, 3, 1, 8'd3, 32'hBEEF4567, 0, 0);
      do_req(0, 2'b10, 0, 10'h008, 32'h0, 32'h1122AA44, 0, 2, 0, 8'd0, 32'h0, 0, 0);
      drain();

      // Sign/zero extension
      preload(8'd0, 32'h80FF7F01);
      do_req(0, 2'b00, 0, 10'h003, 32'h0, 32'hFFFFFF80, 0, 2, 0, 8'd0, 32'h0, 0, 0);
      do_req(0, 2'b00, 1, 10'h003, 32'h0, 32'h00000080, 0, 2, 0, 8'd0, 32'h0, 0, 0);
      do_req(0, 2'b01, 0, 10'h000, 32'h0, 32'h00007F01, 0, 2, 0, 8'd0, 32'h0, 0, 0);
      do_req(0, 2'b01, 0, 10'h002, 32'h0, 32'hFFFF80FF, 0, 2, 0, 8'd0, 32'h0, 0, 0);
      do_req(0, 2'b01, 1, 10'h002, 32'h0, 32'h000080FF, 0, 2, 0, 8'd0, 32'h0, 0, 0);
      do_req(0, 2'b00, 0, 10'h001, 32'h0, 32'h0000007F, 0, 2, 0, 8'd0, 32'h0, 0, 0);
      drain();

      // Misaligned accesses
      preload(8'd1, 32'h0BADF00D);
`ifdef LSU_ERR_EN
      do_req(1, 2'b10, 0, 10'h006, 32'hCAFEF00D, 32'h0, 1, 1, 0, 8'd0, 32'h0, 0, 0);
      do_req(0, 2'b01, 0, 10'h003, 32'h0, 32'h0, 1, 1, 0, 8'd0, 32'h0, 0, 0);
      do_req(0, 2'b10, 0, 10'h004, 32'h0, 32'h0BADF00D, 0, 2, 0, 8'd0, 32'h0, 0, 0);
`else
      do_req(1, 2'b10, 0, 10'h006, 32'hCAFEF00D, 32'h0, 0, 2, 1, 8'd1, 32'hCAFEF00D, 0, 0);
      do_req(0, 2'b01, 0, 10'h003, 32'h0, 32'hFFFF80FF, 0, 2, 0, 8'd0, 32'h0, 0, 0);
      do_req(0, 2'b10, 0, 10'h004, 32'h0, 32'hCAFEF00D, 0, 2, 0, 8'd0, 32'h0, 0, 0);
`endif
      drain();

      // Highest byte address, no wrap
      preload(8'd255, 32'h00000000);
      do_req(1, 2'b00, 0, 10'h3FF, 32'h0000005A, 32'h0, 0, 3, 1, 8'd255, 32'h5A000000, 0, 0);
      do_req(0, 2'b00, 1, 10'h3FF, 32'h0, 32'h0000005A, 0, 2, 0, 8'd0, 32'h0, 0, 0);
      drain();

      // Back-to-back with req_valid held high
      do_req(0, 2'b10, 0, 10'h010, 32'h0, 32'hDEADBEEF, 0, 2, 0, 8'd0, 32'h0, 1, 0);
      do_req(0, 2'b00, 1, 10'h000, 32'h0, 32'h00000001, 0, 2, 0, 8'd0, 32'h0, 1, 1);
      do_req(1, 2'b00, 0, 10'h00B, 32'h00000077, 32'h0, 0, 3, 1, 8'd2, 32'h7722AA44, 1, 1);
      do_req(0, 2'b10, 0, 10'h008, 32'h0, 32'h7722AA44, 0, 2, 0, 8'd0, 32'h0, 0, 1);
      drain();

      // Reset asserted during the WRITE cycle of an RMW
      preload(8'd5, 32'h55667788);
      sb_off = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 10'h014; req_wdata = 32'h000000EE;
      check("rmw_ready_before", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rmw_write_we", {31'd0, mem_we}, 32'd1);
      check("rmw_write_wd", mem_wd, 32'h556677EE);
      rst_n = 1'b0;
      #1;
      check("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mid_ready", {31'd0, req_ready}, 32'd0);
      repeat (2) @(negedge clk);
      check("rst_mem_unchanged", mem[5], 32'h55667788);
      check("rst_held_ready", {31'd0, req_ready}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("release_ready", {31'd0, req_ready}, 32'd1);
      check("release_mem_a", {24'd0, mem_a}, 32'd0);
      sb_off = 1'b0;
      repeat (4) @(negedge clk);
      do_req(0, 2'b10, 0, 10'h014, 32'h0, 32'h55667788, 0, 2, 0, 8'd0, 32'h0, 0, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
